// File: rtl/sensor_monitor_if.sv
// Sensor monitor bus: raw sensor levels and fault rules in, qualified fault status out.
// The master side drives sensors/rules, the slave side is the monitor itself.
interface sensor_monitor_if #(
  parameter int NUM_SENSORS = 4,
  parameter int CNT_W       = 8
);
  logic [NUM_SENSORS-1:0] sensors;
  logic [NUM_SENSORS-1:0] crit_mask;
  logic [NUM_SENSORS-1:0] pair_mask;
  logic                   sticky_en;
  logic                   clear;
  logic                   error;
  logic                   pending;
  logic [NUM_SENSORS-1:0] fault_src;
  logic [CNT_W-1:0]       fault_count;

  modport master (
    output sensors, crit_mask, pair_mask, sticky_en, clear,
    input  error, pending, fault_src, fault_count
  );

  modport slave (
    input  sensors, crit_mask, pair_mask, sticky_en, clear,
    output error, pending, fault_src, fault_count
  );
endinterface

// File: rtl/sensor_monitor.sv
// Clocked sensor fault monitor: single/pair fault rules, persistence filter,
// follow or sticky reporting, saturating event counter and offending-sensor snapshot.
module sensor_monitor #(
  parameter int NUM_SENSORS = 4,
  parameter int PERSIST     = 3,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  sensor_monitor_if.slave sm_if
);
  localparam int             PCW      = (PERSIST > 1) ? $clog2(PERSIST) : 1;
  localparam logic [PCW-1:0] LAST_CNT = PCW'(PERSIST - 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [PCW-1:0]         r_cnt;
  logic [NUM_SENSORS-1:0] r_s_p0;
  logic [NUM_SENSORS-1:0] r_fault_src;
  logic [CNT_W-1:0]       r_fault_count;
  logic                   r_error;
  logic                   r_pending;
  logic                   w_raw;
  logic                   w_new_event;

  function automatic logic two_or_more(input logic [NUM_SENSORS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (v[i]) n++;
    end
    return (n >= 2);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage p0: registered sensors feed the rule decode with the live masks
  assign w_raw = (|(r_s_p0 & sm_if.crit_mask)) | two_or_more(r_s_p0 & sm_if.pair_mask);

  // Only entries from OK/PENDING are new events; HOLD -> FAULT continues the old one
  assign w_new_event = w_raw &&
                       (((r_state == ST_OK) && (PERSIST == 1)) ||
                        ((r_state == ST_PENDING) && (r_cnt == LAST_CNT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_OK;
      r_cnt         <= '0;
      r_s_p0        <= '0;
      r_fault_src   <= '0;
      r_fault_count <= '0;
      r_error       <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_s_p0    <= sm_if.sensors;
      r_cnt     <= '0;
      r_error   <= 1'b0;
      r_pending <= 1'b0;

      if (w_new_event) r_fault_src <= r_s_p0;

      if (sm_if.clear)      r_fault_count <= '0;
      else if (w_new_event) r_fault_count <= sat_inc(r_fault_count);

      case (r_state)
        ST_OK: begin
          if (w_raw) begin
            if (PERSIST == 1) begin
              r_state <= ST_FAULT;
              r_error <= 1'b1;
            end else begin
              r_state   <= ST_PENDING;
              r_cnt     <= PCW'(1);
              r_pending <= 1'b1;
            end
          end
        end
        ST_PENDING: begin
          if (!w_raw) begin
            r_state <= ST_OK;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= ST_FAULT;
            r_error <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + PCW'(1);
            r_pending <= 1'b1;
          end
        end
        ST_FAULT: begin
          r_error <= 1'b1;
          if (!w_raw) begin
            if (sm_if.sticky_en) begin
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_OK;
              r_error <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (w_raw) begin
            r_state <= ST_FAULT;
            r_error <= 1'b1;
          end else if (sm_if.clear || !sm_if.sticky_en) begin
            r_state <= ST_OK;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= ST_OK;
      endcase
    end
  end

  assign sm_if.error       = r_error;
  assign sm_if.pending     = r_pending;
  assign sm_if.fault_src   = r_fault_src;
  assign sm_if.fault_count = r_fault_count;
endmodule
